// File: rtl/punt_bridge_if.sv
// CPU-side and MCU-side signal bundle for punt_bridge.
// The bridge takes the slave modport; the CPU/MCU model or top-level pad ring takes master.
interface punt_bridge_if #(
    parameter int NUM_WIN = 4,
    parameter int ADDR_W  = 24,
    parameter int IDX_W   = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
);
    logic                      AS20;
    logic                      RW;
    logic [ADDR_W-1:0]         A;
    logic                      ENABLE;
    logic [NUM_WIN-1:0]        WIN_EN;
    logic [NUM_WIN*ADDR_W-1:0] WIN_BASE;
    logic [NUM_WIN*ADDR_W-1:0] WIN_MASK;
    logic                      PUNT_IN;
    logic                      PUNT_OE;
    logic [NUM_WIN-1:0]        REQ;
    logic [IDX_W-1:0]          REQ_IDX;
    logic                      REQ_RW;
    logic                      MCU_ACK;
    logic                      DSACK_OE;
    logic [1:0]                DSACK_O;
    logic                      BERR_OE;
    logic                      BUSY;

    modport master (
        output AS20, RW, A, ENABLE, WIN_EN, WIN_BASE, WIN_MASK, PUNT_IN, MCU_ACK,
        input  PUNT_OE, REQ, REQ_IDX, REQ_RW, DSACK_OE, DSACK_O, BERR_OE, BUSY
    );

    modport slave (
        input  AS20, RW, A, ENABLE, WIN_EN, WIN_BASE, WIN_MASK, PUNT_IN, MCU_ACK,
        output PUNT_OE, REQ, REQ_IDX, REQ_RW, DSACK_OE, DSACK_O, BERR_OE, BUSY
    );
endinterface

// File: rtl/punt_bridge.sv
// Window-decoded punt of 68020 cycles to the MCU; DSACK 8-bit termination on synchronised ACK,
// bus error on timeout. Claim visible 1 edge after AS20 low; ACK rise to DSACK = SYNC_STAGES+1 edges.
module punt_bridge #(
    parameter int NUM_WIN     = 4,
    parameter int ADDR_W      = 24,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255,
    parameter int TO_W        = 8,
    parameter int IDX_W       = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
    input  logic          CLKCPU_A,
    input  logic          RESET,
    punt_bridge_if.slave  cpu
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_TERM = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t                 state;
    logic [TO_W-1:0]        cnt;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_hist;
    logic                   ack_rise;

    logic [NUM_WIN-1:0]     hit;
    logic                   hit_any;
    logic [NUM_WIN-1:0]     sel_oh;
    logic [IDX_W-1:0]       sel;

    // Walk downwards so the lowest matching window is the one left standing.
    always_comb begin
        hit    = '0;
        sel_oh = '0;
        sel    = '0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            hit[i] = cpu.ENABLE & cpu.WIN_EN[i] &
                     (((cpu.A ^ cpu.WIN_BASE[i*ADDR_W +: ADDR_W]) &
                       cpu.WIN_MASK[i*ADDR_W +: ADDR_W]) == '0);
            if (hit[i]) begin
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
                sel       = IDX_W'(i);
            end
        end
    end

    assign hit_any     = |hit;
    assign cpu.PUNT_OE = ~cpu.PUNT_IN | hit_any;

    always_ff @(posedge CLKCPU_A) begin
        if (RESET) begin
            ack_sync <= '0;
            ack_hist <= 1'b0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], cpu.MCU_ACK};
            ack_hist <= ack_sync[SYNC_STAGES-1];
        end
    end

    assign ack_rise = ack_sync[SYNC_STAGES-1] & ~ack_hist;

    always_ff @(posedge CLKCPU_A) begin
        if (RESET) begin
            state        <= S_IDLE;
            cnt          <= '0;
            cpu.REQ      <= '0;
            cpu.REQ_IDX  <= '0;
            cpu.REQ_RW   <= 1'b0;
            cpu.DSACK_OE <= 1'b0;
            cpu.DSACK_O  <= 2'b11;
            cpu.BERR_OE  <= 1'b0;
            cpu.BUSY     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!cpu.AS20 && cpu.PUNT_IN && hit_any) begin
                        state       <= S_REQ;
                        cnt         <= '0;
                        cpu.REQ     <= sel_oh;
                        cpu.REQ_IDX <= sel;
                        cpu.REQ_RW  <= cpu.RW;
                        cpu.BUSY    <= 1'b1;
                    end
                end
                S_REQ: begin
                    // Abort beats ACK beats timeout; the timeout exit keeps cnt from wrapping.
                    if (cpu.AS20) begin
                        state    <= S_IDLE;
                        cpu.REQ  <= '0;
                        cpu.BUSY <= 1'b0;
                    end else if (ack_rise) begin
                        state        <= S_TERM;
                        cpu.REQ      <= '0;
                        cpu.DSACK_OE <= 1'b1;
                        cpu.DSACK_O  <= 2'b10;
                    end else if (cnt == TO_W'(TIMEOUT - 1)) begin
                        state       <= S_ERR;
                        cpu.REQ     <= '0;
                        cpu.BERR_OE <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_TERM: begin
                    if (cpu.AS20) begin
                        state        <= S_IDLE;
                        cpu.DSACK_OE <= 1'b0;
                        cpu.DSACK_O  <= 2'b11;
                        cpu.BUSY     <= 1'b0;
                    end
                end
                S_ERR: begin
                    if (cpu.AS20) begin
                        state       <= S_IDLE;
                        cpu.BERR_OE <= 1'b0;
                        cpu.BUSY    <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_punt_bridge.sv
// Directed-vector bench for punt_bridge: decode priority, ACK termination, timeout, abort, reset.
module tb_punt_bridge;
    localparam int NW = 4;
    localparam int AW = 24;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    punt_bridge_if #(.NUM_WIN(NW), .ADDR_W(AW), .IDX_W(IW)) bus ();

    punt_bridge #(
        .NUM_WIN(NW), .ADDR_W(AW), .SYNC_STAGES(2),
        .TIMEOUT(255), .TO_W(8), .IDX_W(IW)
    ) dut (
        .CLKCPU_A(clk),
        .RESET   (rst),
        .cpu     (bus)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_win(input int i, input logic [AW-1:0] base, input logic [AW-1:0] mask);
        bus.WIN_BASE[i*AW +: AW] = base;
        bus.WIN_MASK[i*AW +: AW] = mask;
    endtask

    initial begin
        rst          = 1'b1;
        bus.AS20     = 1'b1;
        bus.RW       = 1'b1;
        bus.A        = '0;
        bus.ENABLE   = 1'b1;
        bus.WIN_EN   = '0;
        bus.WIN_BASE = '0;
        bus.WIN_MASK = '0;
        bus.PUNT_IN  = 1'b1;
        bus.MCU_ACK  = 1'b0;
        tick(2);

        chk("rst_req",      32'(bus.REQ),      32'h0);
        chk("rst_req_idx",  32'(bus.REQ_IDX),  32'h0);
        chk("rst_req_rw",   32'(bus.REQ_RW),   32'h0);
        chk("rst_dsack_oe", 32'(bus.DSACK_OE), 32'h0);
        chk("rst_dsack_o",  32'(bus.DSACK_O),  32'h3);
        chk("rst_berr",     32'(bus.BERR_OE),  32'h0);
        chk("rst_busy",     32'(bus.BUSY),     32'h0);
        rst = 1'b0;
        tick();

        // Basic read claim through window 1 and ACK termination.
        set_win(1, 24'hDC0000, 24'hFF0000);
        bus.WIN_EN = 4'b0010;
        bus.A      = 24'hDC0042;
        bus.RW     = 1'b1;
        bus.AS20   = 1'b0;
        #1;
        chk("t1_punt_oe_comb", 32'(bus.PUNT_OE), 32'h1);
        chk("t1_busy_pre",     32'(bus.BUSY),    32'h0);
        tick();
        chk("t1_req",     32'(bus.REQ),     32'h2);
        chk("t1_req_idx", 32'(bus.REQ_IDX), 32'h1);
        chk("t1_req_rw",  32'(bus.REQ_RW),  32'h1);
        chk("t1_busy",    32'(bus.BUSY),    32'h1);
        bus.MCU_ACK = 1'b1;
        tick(2);
        chk("t1_dsack_early", 32'(bus.DSACK_OE), 32'h0);
        tick();
        chk("t1_dsack_oe",  32'(bus.DSACK_OE), 32'h1);
        chk("t1_dsack_o",   32'(bus.DSACK_O),  32'h2);
        chk("t1_req_clear", 32'(bus.REQ),      32'h0);
        bus.MCU_ACK = 1'b0;
        bus.AS20    = 1'b1;
        chk("t1_dsack_hold", 32'(bus.DSACK_OE), 32'h1);
        tick();
        chk("t1_dsack_rel",   32'(bus.DSACK_OE), 32'h0);
        chk("t1_dsack_o_rel", 32'(bus.DSACK_O),  32'h3);
        chk("t1_busy_rel",    32'(bus.BUSY),     32'h0);
        tick(3);

        // Overlapping windows 0 and 2: lowest enabled index wins.
        set_win(0, 24'hDF0000, 24'hFF0000);
        set_win(2, 24'hDFF000, 24'hFFF000);
        bus.WIN_EN = 4'b0111;
        bus.A      = 24'hDFF00A;
        bus.RW     = 1'b0;
        bus.AS20   = 1'b0;
        tick();
        chk("t2_req_w0",  32'(bus.REQ),     32'h1);
        chk("t2_idx_w0",  32'(bus.REQ_IDX), 32'h0);
        chk("t2_rw_w0",   32'(bus.REQ_RW),  32'h0);
        bus.AS20 = 1'b1;
        tick();
        chk("t2_abort_busy", 32'(bus.BUSY), 32'h0);
        bus.WIN_EN = 4'b0110;
        bus.AS20   = 1'b0;
        tick();
        chk("t2_req_w2", 32'(bus.REQ),     32'h4);
        chk("t2_idx_w2", 32'(bus.REQ_IDX), 32'h2);
        bus.AS20 = 1'b1;
        tick(2);

        // No ACK: bus error exactly 255 edges after REQ appears.
        bus.WIN_EN = 4'b0010;
        bus.A      = 24'hDC0042;
        bus.RW     = 1'b1;
        bus.AS20   = 1'b0;
        tick();
        chk("t3_busy", 32'(bus.BUSY), 32'h1);
        tick(254);
        chk("t3_berr_early", 32'(bus.BERR_OE), 32'h0);
        chk("t3_req_held",   32'(bus.REQ),     32'h2);
        tick();
        chk("t3_berr",     32'(bus.BERR_OE),  32'h1);
        chk("t3_req_clr",  32'(bus.REQ),      32'h0);
        chk("t3_no_dsack", 32'(bus.DSACK_OE), 32'h0);
        bus.AS20 = 1'b1;
        tick();
        chk("t3_berr_rel", 32'(bus.BERR_OE), 32'h0);
        chk("t3_busy_rel", 32'(bus.BUSY),    32'h0);
        tick(2);

        // ACK already high at claim is ignored until it falls and rises again.
        bus.MCU_ACK = 1'b1;
        tick(4);
        bus.AS20 = 1'b0;
        tick();
        tick(5);
        chk("t4_level_ignored", 32'(bus.DSACK_OE), 32'h0);
        chk("t4_still_busy",    32'(bus.BUSY),     32'h1);
        bus.MCU_ACK = 1'b0;
        tick(3);
        bus.MCU_ACK = 1'b1;
        tick(2);
        chk("t4_rerise_early", 32'(bus.DSACK_OE), 32'h0);
        tick();
        chk("t4_rerise_dsack", 32'(bus.DSACK_OE), 32'h1);
        bus.AS20    = 1'b1;
        bus.MCU_ACK = 1'b0;
        tick();
        chk("t4_rel", 32'(bus.DSACK_OE), 32'h0);
        tick(3);

        // Abort coinciding with an ACK rise: abort wins.
        bus.AS20 = 1'b0;
        tick();
        bus.MCU_ACK = 1'b1;
        tick(2);
        bus.AS20 = 1'b1;
        tick();
        chk("t4_abort_busy",  32'(bus.BUSY),     32'h0);
        chk("t4_abort_dsack", 32'(bus.DSACK_OE), 32'h0);
        chk("t4_abort_berr",  32'(bus.BERR_OE),  32'h0);
        chk("t4_abort_req",   32'(bus.REQ),      32'h0);
        bus.MCU_ACK = 1'b0;
        tick(3);

        // Accelerator punt passes through without a claim; ENABLE=0 blocks decode.
        bus.PUNT_IN = 1'b0;
        bus.AS20    = 1'b0;
        #1;
        chk("t5_punt_pass", 32'(bus.PUNT_OE), 32'h1);
        tick();
        chk("t5_no_claim", 32'(bus.BUSY), 32'h0);
        chk("t5_no_req",   32'(bus.REQ),  32'h0);
        bus.PUNT_IN = 1'b1;
        bus.ENABLE  = 1'b0;
        #1;
        chk("t5_disabled_punt", 32'(bus.PUNT_OE), 32'h0);
        tick();
        chk("t5_disabled_req", 32'(bus.REQ), 32'h0);
        bus.AS20   = 1'b1;
        bus.ENABLE = 1'b1;
        tick();

        // Reset while terminating.
        bus.AS20 = 1'b0;
        tick();
        bus.MCU_ACK = 1'b1;
        tick(3);
        chk("t6_in_term", 32'(bus.DSACK_OE), 32'h1);
        rst = 1'b1;
        tick();
        chk("t6_rst_dsack_oe", 32'(bus.DSACK_OE), 32'h0);
        chk("t6_rst_dsack_o",  32'(bus.DSACK_O),  32'h3);
        chk("t6_rst_busy",     32'(bus.BUSY),     32'h0);
        rst         = 1'b0;
        bus.MCU_ACK = 1'b0;
        bus.AS20    = 1'b1;
        tick(3);

        // ACK rise on the timeout edge wins; ENABLE dropping after claim has no effect.
        bus.AS20 = 1'b0;
        tick();
        bus.ENABLE = 1'b0;
        tick(252);
        bus.MCU_ACK = 1'b1;
        tick(3);
        chk("t6_coinc_dsack", 32'(bus.DSACK_OE), 32'h1);
        chk("t6_coinc_berr",  32'(bus.BERR_OE),  32'h0);
        bus.AS20    = 1'b1;
        bus.MCU_ACK = 1'b0;
        bus.ENABLE  = 1'b1;
        tick();
        chk("t6_coinc_rel", 32'(bus.BUSY), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
